// File: rtl/qsys_conduit_to_avst_hw.sv
// Conduit-to-Avalon-ST source adapter: captures a raw conduit bus, qualifies samples by change
// detection or valid strobe, and streams them out of a small show-ahead FIFO with backpressure.
module qsys_conduit_to_avst_hw #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CHANGE_ONLY = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                sigIn,
    input  logic                            sigValid,
    output logic [WIDTH-1:0]                srcData,
    output logic                            srcValid,
    input  logic                            srcReady,
    input  logic                            clearOverflow,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fillLevel
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] s_in_q;
    logic             s_val_q;
    logic [WIDTH-1:0] last_val_q;
    logic             first_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             ovf_q;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic want;
    logic pop;
    logic push;
    logic full;

    always_comb begin
        want = s_val_q && ((CHANGE_ONLY == 0) || first_q || (s_in_q != last_val_q));
        full = (level_q == LW'(FIFO_DEPTH));
        pop  = srcValid && srcReady;
        // A full FIFO still accepts a sample when a beat leaves in the same cycle.
        push = want && (!full || pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_in_q     <= '0;
            s_val_q    <= 1'b0;
            last_val_q <= '0;
            first_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s_in_q  <= sigIn;
            s_val_q <= sigValid;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + AW'(1);
                last_val_q <= s_in_q;
                first_q    <= 1'b0;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (!push && pop) begin
                level_q <= level_q - LW'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (want && !push) begin
                ovf_q <= 1'b1;
            end else if (clearOverflow) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_in_q;
        end
    end

    always_comb begin
        srcData   = mem_q[rd_ptr_q];
        srcValid  = (level_q != '0);
        overflow  = ovf_q;
        fillLevel = level_q;
    end

endmodule

// File: tb/tb_qsys_conduit_to_avst_hw.sv
// Bench for qsys_conduit_to_avst_hw: vector table, directed corner sequences and randomized
// stimulus checked against a list-based reference model (change-only and every-sample builds).
module tb_qsys_conduit_to_avst_hw;

    logic       clk;
    logic       rst;
    logic [3:0] sig_in;
    logic       sig_val;
    logic       src_rdy;
    logic       clr_ovf;

    logic [3:0] d1_data, d0_data;
    logic       d1_valid, d0_valid;
    logic       d1_ovf, d0_ovf;
    logic [2:0] d1_lvl, d0_lvl;

    int passed = 0;
    int total  = 0;

    qsys_conduit_to_avst_hw #(.WIDTH(4), .FIFO_DEPTH(4), .CHANGE_ONLY(1)) dut1 (
        .clock(clk), .reset(rst), .sigIn(sig_in), .sigValid(sig_val),
        .srcData(d1_data), .srcValid(d1_valid), .srcReady(src_rdy),
        .clearOverflow(clr_ovf), .overflow(d1_ovf), .fillLevel(d1_lvl)
    );

    qsys_conduit_to_avst_hw #(.WIDTH(4), .FIFO_DEPTH(4), .CHANGE_ONLY(0)) dut0 (
        .clock(clk), .reset(rst), .sigIn(sig_in), .sigValid(sig_val),
        .srcData(d0_data), .srcValid(d0_valid), .srcReady(src_rdy),
        .clearOverflow(clr_ovf), .overflow(d0_ovf), .fillLevel(d0_lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of held samples, head at items[0].
    typedef struct packed {
        logic [3:0][3:0] items;
        logic [2:0]      cnt;
        logic [3:0]      cap_in;
        logic            cap_val;
        logic [3:0]      last;
        logic            first;
        logic            ovf;
    } mdl_t;

    mdl_t m1, m0;

    function automatic mdl_t mstep(input mdl_t s, input bit co);
        mdl_t n;
        bit want, pop, push;
        n = s;
        if (rst) begin
            n.cnt = 0; n.cap_in = 0; n.cap_val = 0; n.last = 0; n.first = 1; n.ovf = 0;
        end else begin
            want = s.cap_val && (!co || s.first || (s.cap_in != s.last));
            pop  = (s.cnt != 0) && src_rdy;
            push = want && ((s.cnt < 4) || pop);
            if (pop) begin
                for (int i = 0; i < 3; i++) n.items[i] = n.items[i+1];
                n.cnt = n.cnt - 1;
            end
            if (push) begin
                n.items[n.cnt] = s.cap_in;
                n.cnt   = n.cnt + 1;
                n.last  = s.cap_in;
                n.first = 0;
            end
            if (want && !push) n.ovf = 1;
            else if (clr_ovf)  n.ovf = 0;
            n.cap_in  = sig_in;
            n.cap_val = sig_val;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp_model();
        chk("m1_valid", 32'(d1_valid), 32'(m1.cnt != 0));
        chk("m1_level", 32'(d1_lvl), 32'(m1.cnt));
        chk("m1_ovf", 32'(d1_ovf), 32'(m1.ovf));
        if (m1.cnt != 0) chk("m1_data", 32'(d1_data), 32'(m1.items[0]));
        chk("m0_valid", 32'(d0_valid), 32'(m0.cnt != 0));
        chk("m0_level", 32'(d0_lvl), 32'(m0.cnt));
        chk("m0_ovf", 32'(d0_ovf), 32'(m0.ovf));
        if (m0.cnt != 0) chk("m0_data", 32'(d0_data), 32'(m0.items[0]));
    endtask

    // Apply current inputs across one rising edge, then sample 1 time unit later.
    task automatic step();
        m1 = mstep(m1, 1'b1);
        m0 = mstep(m0, 1'b0);
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic drive(input logic r, input logic [3:0] s, input logic v, input logic rd,
                         input logic c);
        rst = r; sig_in = s; sig_val = v; src_rdy = rd; clr_ovf = c;
    endtask

    typedef struct packed {
        logic       rst;
        logic [3:0] sig;
        logic       sval;
        logic       rdy;
        logic       clr;
        logic       evalid;
        logic [3:0] edata;
        logic [2:0] elvl;
        logic       eovf;
    } vec_t;

    vec_t tbl [12];
    int   beats;

    initial begin
        m1 = '0; m0 = '0;
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

        // Change-only build: held value gives one beat; then a backpressured burst of 1,2,3.
        tbl[0]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 3'd1, 1'b0};
        tbl[3]  = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[5]  = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 3'd1, 1'b0};
        tbl[7]  = '{1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 3'd2, 1'b0};
        tbl[8]  = '{1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 3'd3, 1'b0};
        tbl[9]  = '{1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 3'd2, 1'b0};
        tbl[10] = '{1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 3'd1, 1'b0};
        tbl[11] = '{1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].sig, tbl[i].sval, tbl[i].rdy, tbl[i].clr);
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(d1_valid), 32'(tbl[i].evalid));
            chk($sformatf("tbl%0d_level", i), 32'(d1_lvl), 32'(tbl[i].elvl));
            chk($sformatf("tbl%0d_ovf", i), 32'(d1_ovf), 32'(tbl[i].eovf));
            if (tbl[i].evalid) chk($sformatf("tbl%0d_data", i), 32'(d1_data), 32'(tbl[i].edata));
        end

        // Overflow: 1..6 into a 4-deep FIFO with no ready, drain, then clear.
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0); step();
        for (int v = 1; v <= 6; v++) begin drive(1'b0, 4'(v), 1'b1, 1'b0, 1'b0); step(); end
        chk("t3_ovf_set", 32'(d1_ovf), 32'd1);
        step();
        drive(1'b0, 4'd6, 1'b0, 1'b0, 1'b0); step(); step();
        chk("t3_full", 32'(d1_lvl), 32'd4);
        src_rdy = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            chk($sformatf("t3_beat%0d", v), 32'(d1_data), 32'(v));
            step();
        end
        chk("t3_empty", 32'(d1_valid), 32'd0);
        chk("t3_ovf_sticky", 32'(d1_ovf), 32'd1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("t3_ovf_clr", 32'(d1_ovf), 32'd0);

        // Full FIFO accepting a new sample during a same-cycle pop.
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0); step();
        for (int v = 1; v <= 4; v++) begin drive(1'b0, 4'(v), 1'b1, 1'b0, 1'b0); step(); end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0); step();
        chk("t4_full", 32'(d1_lvl), 32'd4);
        drive(1'b0, 4'd9, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 4'd9, 1'b0, 1'b1, 1'b0); step();
        chk("t4_level_kept", 32'(d1_lvl), 32'd4);
        chk("t4_no_ovf", 32'(d1_ovf), 32'd0);
        chk("t4_head2", 32'(d1_data), 32'd2);
        step(); chk("t4_head3", 32'(d1_data), 32'd3);
        step(); chk("t4_head4", 32'(d1_data), 32'd4);
        step(); chk("t4_head9", 32'(d1_data), 32'd9);
        step(); chk("t4_empty", 32'(d1_valid), 32'd0);

        // Reset mid-operation discards data; a 0 sample is still pushed first afterwards.
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0); step();
        for (int v = 1; v <= 3; v++) begin drive(1'b0, 4'(v), 1'b1, 1'b0, 1'b0); step(); end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0); step();
        chk("t5_level3", 32'(d1_lvl), 32'd3);
        rst = 1'b1; step();
        chk("t5_rst_valid", 32'(d1_valid), 32'd0);
        chk("t5_rst_level", 32'(d1_lvl), 32'd0);
        chk("t5_rst_ovf", 32'(d1_ovf), 32'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0); step();
        sig_val = 1'b0; step();
        chk("t5_zero_valid", 32'(d1_valid), 32'd1);
        chk("t5_zero_data", 32'(d1_data), 32'd0);
        step();
        chk("t5_one_beat", 32'(d1_valid), 32'd0);

        // Every-sample build: three valid cycles of 7 give exactly three beats.
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0); step();
        beats = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 4'd7, (c < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            step();
            if (d0_valid) begin
                beats++;
                chk("t6_data", 32'(d0_data), 32'd7);
            end
        end
        chk("t6_beats", 32'(beats), 32'd3);

        // Randomized stimulus, every cycle compared against the reference model.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(63) == 0), 4'($urandom_range(3)), ($urandom_range(3) != 0),
                  ($urandom_range(9) < 6), ($urandom_range(15) == 0));
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
